ecdsa_op_sequencer: RTL

- Command-driven controller between the AXI-lite CSR block and the shared 1024-bit operand memory.
- On start, it reads an address table from memory, then fetches up to MAX_ARGS 1024-bit operands and loads each into the arithmetic core's operand registers.
- It then launches the core, waits for completion, writes the 1024-bit result back to memory, and reports done/error status to the CSRs.

---
 rtl/ecdsa_pkg.sv | 34 +++
 rtl/ecdsa_rd_wait.sv | 28 ++
 rtl/ecdsa_op_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ecdsa_pkg.sv
// Shared types and helpers for the ECDSA operand sequencer.
// Word geometry of the 1024-bit operand memory and the FSM state set.
package ecdsa_pkg;

  localparam int WORD_W    = 1024;
  localparam int SLOT_W    = 32;
  localparam int MEM_AW    = 17;
  localparam int BYTE_EN_W = 128;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TBL_RD,
    S_TBL_WAIT,
    S_ARG_RD,
    S_ARG_WAIT,
    S_LOAD,
    S_START,
    S_WAIT_CORE,
    S_WB,
    S_DONE,
    S_ERR
  } state_t;

  // Slot s holds word[1023-32s : 992-32s]; the address is its low half.
  function automatic logic [15:0] slot_addr(
    input logic [WORD_W-1:0] word,
    input logic [4:0]        s
  );
    int b;
    b = (WORD_W - 17) - SLOT_W * int'(s);
    return word[b -: 16];
  endfunction

endpackage

// File: rtl/ecdsa_rd_wait.sv
// Read-latency tracker: raises valid exactly LAT cycles after issue.
// Shared by the table read and every argument read.
module ecdsa_rd_wait #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic issue,
  output logic valid
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (issue) begin
      cnt <= CW'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign valid = (cnt == CW'(1));

endmodule

// File: rtl/ecdsa_op_sequencer.sv
// Command sequencer: table fetch, operand loads, core launch and
// result write-back between the CSRs and the 1024-bit operand memory.
module ecdsa_op_sequencer
  import ecdsa_pkg::*;
#(
  parameter int MAX_ARGS    = 4,
  parameter int MEM_RD_LAT  = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_start,
  input  logic [31:0]          table_base,
  input  logic [3:0]           argc,
  input  logic [31:0]          res_addr,
  output logic                 status_busy,
  output logic                 status_done,
  output logic                 status_err,
  output logic                 mem_en,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [BYTE_EN_W-1:0] mem_we,
  output logic [WORD_W-1:0]    mem_din,
  input  logic [WORD_W-1:0]    mem_dout,
  output logic                 op_load,
  output logic [2:0]           op_idx,
  output logic [WORD_W-1:0]    op_data,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [WORD_W-1:0]    core_result
);

  state_t state, nxt;

  logic              armed;
  logic [2:0]        idx;
  logic [3:0]        argc_q;
  logic [9:0]        tbl_q;
  logic [9:0]        res_q;
  logic [WORD_W-1:0] tbl_word;
  logic [WORD_W-1:0] data_q;
  logic [31:0]       wd;
  logic              rd_issue;
  logic              rd_valid;
  logic              argc_ok;
  logic              last;
  logic              wd_hit;
  logic [4:0]        slot;
  logic [15:0]       arg_addr;
  logic              unused_bits;

  ecdsa_rd_wait #(
    .LAT(MEM_RD_LAT)
  ) u_rd_wait (
    .clk   (clk),
    .resetn(resetn),
    .issue (rd_issue),
    .valid (rd_valid)
  );

  assign argc_ok  = (argc != 4'd0) && (int'(argc) <= MAX_ARGS);
  assign slot     = 5'(argc_q - 4'd1 - {1'b0, idx});
  assign arg_addr = slot_addr(tbl_word, slot);
  assign last     = (({1'b0, idx} + 4'd1) == argc_q);
  assign wd_hit   = (TIMEOUT_CYC != 0) &&
                    (wd == 32'(TIMEOUT_CYC - 1));

  assign unused_bits = ^{table_base[31:17], table_base[6:0],
                         res_addr[31:17], res_addr[6:0],
                         arg_addr[6:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt         = state;
    status_busy = 1'b1;
    status_done = 1'b0;
    status_err  = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    mem_we      = '0;
    mem_din     = '0;
    op_load     = 1'b0;
    op_idx      = '0;
    op_data     = '0;
    core_start  = 1'b0;
    rd_issue    = 1'b0;
    unique case (state)
      S_IDLE: begin
        status_busy = 1'b0;
        if (armed && cmd_start) begin
          nxt = argc_ok ? S_TBL_RD : S_ERR;
        end
      end
      S_TBL_RD: begin
        mem_en   = 1'b1;
        mem_addr = {tbl_q, 7'b0};
        rd_issue = 1'b1;
        nxt      = S_TBL_WAIT;
      end
      S_TBL_WAIT: begin
        if (rd_valid) nxt = S_ARG_RD;
      end
      S_ARG_RD: begin
        mem_en   = 1'b1;
        mem_addr = {1'b0, arg_addr[15:7], 7'b0};
        rd_issue = 1'b1;
        nxt      = S_ARG_WAIT;
      end
      S_ARG_WAIT: begin
        if (rd_valid) nxt = S_LOAD;
      end
      S_LOAD: begin
        op_load = 1'b1;
        op_idx  = idx;
        op_data = data_q;
        nxt     = last ? S_START : S_ARG_RD;
      end
      S_START: begin
        core_start = 1'b1;
        nxt        = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (core_done) nxt = S_WB;
        else if (wd_hit) nxt = S_ERR;
      end
      S_WB: begin
        // gated so a reset landing on this cycle never commits a write
        mem_en   = resetn;
        mem_we   = {BYTE_EN_W{resetn}};
        mem_addr = {res_q, 7'b0};
        mem_din  = data_q;
        nxt      = S_DONE;
      end
      S_DONE: begin
        status_busy = 1'b0;
        status_done = 1'b1;
        if (!cmd_start) nxt = S_IDLE;
      end
      S_ERR: begin
        status_busy = 1'b0;
        status_err  = 1'b1;
        if (!cmd_start) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      armed    <= 1'b0;
      idx      <= '0;
      argc_q   <= '0;
      tbl_q    <= '0;
      res_q    <= '0;
      tbl_word <= '0;
      data_q   <= '0;
      wd       <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (!cmd_start) begin
          armed <= 1'b1;
        end else if (armed) begin
          armed  <= 1'b0;
          argc_q <= argc;
          tbl_q  <= table_base[16:7];
          res_q  <= res_addr[16:7];
        end
      end
      if (state == S_TBL_WAIT && rd_valid) begin
        tbl_word <= mem_dout;
        idx      <= '0;
      end
      if (state == S_ARG_WAIT && rd_valid) data_q <= mem_dout;
      if (state == S_LOAD) idx <= idx + 3'd1;
      if (state == S_START) wd <= '0;
      else if (state == S_WAIT_CORE) wd <= wd + 32'd1;
      if (state == S_WAIT_CORE && core_done) data_q <= core_result;
    end
  end

endmodule
